// File: rtl/resize_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : resize_scan_controller
// Description : Raster sequencer for the 2x upscaling path. Walks the source
//               frame, issues pixel reads, and turns the returned 24-bit
//               pixels into an r/g/b + horizontal_sync beat stream. Inserts
//               inter-line gaps, honours sink backpressure, flags frame end.
// Options     : SCAN_BOTTOM_UP_EN - issue rows from HEIGHT-1 down to 0
//               (BMP bottom-up order); default is top-down.
// Revision    : 1.0 - initial release
// ============================================================================
module resize_scan_controller #(
  parameter int WIDTH      = 384,
  parameter int HEIGHT     = 256,
  parameter int RD_LATENCY = 1,
  parameter int LINE_GAP   = 4,
  parameter int ADDR_W     = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              sink_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              horizontal_sync,
  output logic              busy,
  output logic              frame_done
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

  localparam logic [COL_W-1:0] c_col_last = COL_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] c_gap_last = (LINE_GAP > 0) ? GAP_W'(LINE_GAP - 1) : '0;

`ifdef SCAN_BOTTOM_UP_EN
  // Bottom-up: start on the last row; a row wrap steps back one row from the
  // column past the end, i.e. address moves by -(2*WIDTH-1).
  localparam logic [ROW_W-1:0]  c_row_first  = ROW_W'(HEIGHT - 1);
  localparam logic [ROW_W-1:0]  c_row_final  = '0;
  localparam logic [ROW_W-1:0]  c_row_step   = '1;
  localparam logic [ADDR_W-1:0] c_addr_first = ADDR_W'((HEIGHT - 1) * WIDTH);
  localparam logic [ADDR_W-1:0] c_addr_wrap  = ADDR_W'(0) - ADDR_W'(2 * WIDTH - 1);
`else
  // Top-down: addresses are simply contiguous across row boundaries.
  localparam logic [ROW_W-1:0]  c_row_first  = '0;
  localparam logic [ROW_W-1:0]  c_row_final  = ROW_W'(HEIGHT - 1);
  localparam logic [ROW_W-1:0]  c_row_step   = ROW_W'(1);
  localparam logic [ADDR_W-1:0] c_addr_first = '0;
  localparam logic [ADDR_W-1:0] c_addr_wrap  = ADDR_W'(1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_GAP    = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [ADDR_W-1:0]     r_addr;
  logic [GAP_W-1:0]      r_gap;
  logic [RD_LATENCY-1:0] r_vld;
  logic [7:0]            r_r;
  logic [7:0]            r_g;
  logic [7:0]            r_b;
  logic                  r_hsync;
  logic                  r_busy;
  logic                  w_rd_en;
  logic                  w_frame_done;
  logic                  w_row_end;
  logic                  w_frame_end;
  logic                  w_tap;

  assign w_row_end   = (r_col == c_col_last);
  assign w_frame_end = w_row_end && (r_row == c_row_final);
  assign w_tap       = r_vld[RD_LATENCY-1];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode plus the read strobe and completion pulse.
  always_comb begin
    w_next       = r_state;
    w_rd_en      = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_STREAM;
      end
      S_STREAM: begin
        w_rd_en = sink_ready;
        if (sink_ready && w_row_end) begin
          if (w_frame_end)       w_next = S_DRAIN;
          else if (LINE_GAP > 0) w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap == c_gap_last) w_next = S_STREAM;
      end
      S_DRAIN: begin
        // Pipeline empty means the final beat is on the output this cycle.
        if (r_vld == '0) w_next = S_DONE;
      end
      S_DONE: begin
        w_frame_done = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Scan position, read address and gap counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
      r_gap  <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_col  <= '0;
        r_row  <= c_row_first;
        r_addr <= c_addr_first;
      end else if (w_rd_en) begin
        r_col  <= w_row_end ? '0 : r_col + COL_W'(1);
        r_addr <= r_addr + (w_row_end ? c_addr_wrap : ADDR_W'(1));
        if (w_row_end) r_row <= r_row + c_row_step;
      end
      r_gap <= (r_state == S_GAP && w_next == S_GAP) ? r_gap + GAP_W'(1) : '0;
    end
  end

  // Valid shift register tracking outstanding reads; captures returned pixels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld   <= '0;
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
      r_hsync <= 1'b0;
    end else begin
      r_vld[0] <= w_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) r_vld[i] <= r_vld[i-1];
      r_hsync <= w_tap;
      if (w_tap) begin
        r_r <= rd_data[23:16];
        r_g <= rd_data[15:8];
        r_b <= rd_data[7:0];
      end
    end
  end

  // Busy covers every in-frame state; low again in the DONE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_busy <= 1'b0;
    else       r_busy <= (w_next == S_STREAM) || (w_next == S_GAP) || (w_next == S_DRAIN);
  end

  assign rd_en           = w_rd_en;
  assign rd_addr         = r_addr;
  assign r               = r_r;
  assign g               = r_g;
  assign b               = r_b;
  assign horizontal_sync = r_hsync;
  assign busy            = r_busy;
  assign frame_done      = w_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_resize_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_resize_scan_controller
// Description : Directed self-checking bench for resize_scan_controller.
//               Instance A: RD_LATENCY=1, LINE_GAP=2. Instance B:
//               RD_LATENCY=3, LINE_GAP=0. Both 4x2 frames. Expected address
//               order follows SCAN_BOTTOM_UP_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resize_scan_controller;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_a, start_b, sink_a, sink_b;
  logic          rd_en_a, rd_en_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [23:0]   data_a, data_b, pb0, pb1;
  logic [7:0]    ra, ga, ba, rb, gb, bb;
  logic          hs_a, hs_b, busy_a, busy_b, fd_a, fd_b;
  int            cyc = 0;

  always #5 clk = ~clk;

  resize_scan_controller #(.WIDTH(W), .HEIGHT(H), .RD_LATENCY(1), .LINE_GAP(2), .ADDR_W(AW)) u_dut_a (
    .clock(clk), .reset(rst), .start(start_a), .sink_ready(sink_a),
    .rd_en(rd_en_a), .rd_addr(addr_a), .rd_data(data_a),
    .r(ra), .g(ga), .b(ba), .horizontal_sync(hs_a), .busy(busy_a), .frame_done(fd_a)
  );

  resize_scan_controller #(.WIDTH(W), .HEIGHT(H), .RD_LATENCY(3), .LINE_GAP(0), .ADDR_W(AW)) u_dut_b (
    .clock(clk), .reset(rst), .start(start_b), .sink_ready(sink_b),
    .rd_en(rd_en_b), .rd_addr(addr_b), .rd_data(data_b),
    .r(rb), .g(gb), .b(bb), .horizontal_sync(hs_b), .busy(busy_b), .frame_done(fd_b)
  );

  // Memory contents: a distinct, nonzero pixel per address.
  function automatic logic [23:0] pix(input logic [AW-1:0] a);
    logic [7:0] x;
    x = {4'h0, a};
    return {x * 8'd3 + 8'd1, x ^ 8'h5A, x + 8'h80};
  endfunction

  // Cycle counter and source memory models (latency 1 and latency 3).
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    data_a <= pix(addr_a);
    pb0    <= pix(addr_b);
    pb1    <= pb0;
    data_b <= pb1;
  end

  int iss_addr[$], iss_cyc[$], beat_val[$], beat_cyc[$], done_cyc[$], done_busy[$];
  int viol = 0;

  // Observe both instances away from the active edge.
  always @(negedge clk) begin
    if (rd_en_a) begin
      iss_addr.push_back(int'(addr_a)); iss_cyc.push_back(cyc);
      if (!sink_a) viol++;
    end
    if (rd_en_b) begin
      iss_addr.push_back(int'(addr_b)); iss_cyc.push_back(cyc);
      if (!sink_b) viol++;
    end
    if (hs_a) begin beat_val.push_back(int'({ra, ga, ba})); beat_cyc.push_back(cyc); end
    if (hs_b) begin beat_val.push_back(int'({rb, gb, bb})); beat_cyc.push_back(cyc); end
    if (fd_a) begin done_cyc.push_back(cyc); done_busy.push_back(int'(busy_a)); end
    if (fd_b) begin done_cyc.push_back(cyc); done_busy.push_back(int'(busy_b)); end
  end

  int errs   = 0;
  int checks = 0;
  int exp_addr[8];

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_addr.delete(); iss_cyc.delete(); beat_val.delete();
    beat_cyc.delete(); done_cyc.delete(); done_busy.delete();
    viol = 0;
  endtask

  task automatic pulse_start(input bit sel_b, output int s);
    clear_logs();
    s = cyc;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done_cyc.size() == 0 && n < limit) begin tick(); n++; end
    repeat (4) tick();
  endtask

  task automatic check_frame(input string t, input int s, input int off[8], input int lat);
    check({t, " issue count"}, iss_addr.size(), 8);
    check({t, " beat count"}, beat_val.size(), 8);
    check({t, " no rd_en while stalled"}, viol, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s addr%0d", t, i), (i < iss_addr.size()) ? iss_addr[i] : -1, exp_addr[i]);
      check($sformatf("%s issue_cyc%0d", t, i), (i < iss_cyc.size()) ? iss_cyc[i] - s : -1, off[i]);
      check($sformatf("%s beat_rgb%0d", t, i), (i < beat_val.size()) ? beat_val[i] : -1,
            int'(pix(AW'(exp_addr[i]))));
      check($sformatf("%s beat_cyc%0d", t, i), (i < beat_cyc.size()) ? beat_cyc[i] - s : -1,
            off[i] + lat + 1);
    end
    check({t, " frame_done count"}, done_cyc.size(), 1);
    check({t, " frame_done cyc"}, (done_cyc.size() > 0) ? done_cyc[0] - s : -1, off[7] + lat + 2);
    check({t, " busy in done cycle"}, (done_busy.size() > 0) ? done_busy[0] : -1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int off_a[8], off_bp[8], off_b[8];
    int n_bp;
`ifdef SCAN_BOTTOM_UP_EN
    exp_addr = '{4, 5, 6, 7, 0, 1, 2, 3};
`else
    exp_addr = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    off_a  = '{1, 2, 3, 4, 7, 8, 9, 10};
    off_bp = '{1, 2, 6, 7, 10, 11, 12, 13};
    off_b  = '{1, 2, 3, 4, 5, 6, 7, 8};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sink_a = 1'b1; sink_b = 1'b1;
    repeat (3) tick();
    check("reset rd_en_a", int'(rd_en_a), 0);
    check("reset addr_a", int'(addr_a), 0);
    check("reset rgb_a", int'({ra, ga, ba}), 0);
    check("reset hs_a", int'(hs_a), 0);
    check("reset busy_a", int'(busy_a), 0);
    check("reset done_a", int'(fd_a), 0);
    check("reset busy_b", int'(busy_b), 0);
    rst = 1'b0;
    tick();

    // Basic frame with line gap.
    pulse_start(1'b0, s);
    check("t1 busy after start", int'(busy_a), 1);
    wait_done(60);
    check_frame("t1", s, off_a, 1);
    check("t1 busy after frame", int'(busy_a), 0);

    // Backpressure: sink_ready low for 3 cycles after the 2nd issue.
    pulse_start(1'b0, s);
    tick();
    tick();
    sink_a = 1'b0;
    repeat (3) tick();
    sink_a = 1'b1;
    wait_done(60);
    n_bp = 0;
    foreach (beat_cyc[i]) if (beat_cyc[i] >= s + 3 && beat_cyc[i] <= s + 5) n_bp++;
    check("bp beats while stalled", n_bp, 2);
    check_frame("bp", s, off_bp, 1);

    // Latency 3, no gap: back-to-back issues.
    pulse_start(1'b1, s);
    wait_done(60);
    check_frame("lat3", s, off_b, 3);
    check("lat3 busy after frame", int'(busy_b), 0);

    // Second start mid-frame must be ignored.
    pulse_start(1'b0, s);
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(60);
    repeat (10) tick();
    check_frame("restart", s, off_a, 1);

    // Asynchronous reset mid-frame after five issues.
    pulse_start(1'b0, s);
    repeat (7) tick();
    check("rst issues before reset", iss_addr.size(), 5);
    rst = 1'b1;
    #1;
    check("rst rd_en", int'(rd_en_a), 0);
    check("rst addr", int'(addr_a), 0);
    check("rst rgb", int'({ra, ga, ba}), 0);
    check("rst hs", int'(hs_a), 0);
    check("rst busy", int'(busy_a), 0);
    check("rst done", int'(fd_a), 0);
    clear_logs();
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rst no issues after", iss_addr.size(), 0);
    check("rst no beats after", beat_val.size(), 0);
    check("rst no done after", done_cyc.size(), 0);
    pulse_start(1'b0, s);
    wait_done(60);
    check_frame("post_rst", s, off_a, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
